// File: rtl/char_disp_pkg.sv
// Shared constants and cell-coordinate types for the text-mode renderer.
package char_disp_pkg;

   localparam int   CELL_W            = 8;     // pixels per character cell, horizontally
   localparam int   CELL_H            = 8;     // pixel rows per character cell
   localparam int   LAT               = 5;     // input-to-output latency in clocks
   localparam logic SYNC_IDLE_DEFAULT = 1'b1;  // inactive sync level

   typedef logic [6:0] col_t;                  // text column index
   typedef logic [5:0] row_t;                  // text row index

endpackage

// File: rtl/char_text_renderer_if.sv
// Fetch bus between the renderer and its two memories.
// The renderer drives the text RAM address and the char_gen_rom address.
// The two memories return their data one clock after sampling the address.
interface char_text_renderer_if #(
   parameter int TADDR_W = 13
);
   logic [TADDR_W-1:0] tram_addr;   // text RAM read address
   logic [7:0]         tram_data;   // text RAM read data, bit7 unused
   logic [6:0]         char_addr;   // character code to the font ROM
   logic [2:0]         row_addr;    // pixel row within the glyph
   logic [7:0]         font_data;   // glyph row, bit0 = leftmost pixel

   modport master (output tram_addr, char_addr, row_addr, input tram_data, font_data);
   modport slave  (input tram_addr, char_addr, row_addr, output tram_data, font_data);
endinterface

// File: rtl/char_text_renderer_sig_delay_line.sv
// Fixed-depth register delay line with a synchronous reset value.
// Used for the sync/enable pipe and for the side-band coordinate pipe.
module sig_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] q_reg;
         if (gi == 0) begin : g_first
            // first stage captures the input
            always_ff @(posedge clk) begin
               if (reset) q_reg <= RESET_VAL;
               else       q_reg <= din;
            end
         end else begin : g_next
            // later stages shift the previous stage along
            always_ff @(posedge clk) begin
               if (reset) q_reg <= RESET_VAL;
               else       q_reg <= g_stage[gi-1].q_reg;
            end
         end
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/char_text_renderer.sv
// Pixel-rate text-mode renderer: pixel coordinates -> text RAM read ->
// font ROM read -> coloured pixel, with sync/enable delayed by the same
// five clocks. Optional block cursor is enabled with the CHAR_CURSOR_EN macro.
module char_text_renderer
   import char_disp_pkg::*;
#(
   parameter int   H_CHARS   = 80,
   parameter int   V_ROWS    = 60,
   parameter int   TADDR_W   = 13,
   parameter int   COLOR_W   = 16,
   parameter logic SYNC_IDLE = SYNC_IDLE_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         h_cnt,
   input  logic [9:0]         v_cnt,
   input  logic               de_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   char_text_renderer_if.master mem,
   input  logic [COLOR_W-1:0] fg_color,
   input  logic [COLOR_W-1:0] bg_color,
`ifdef CHAR_CURSOR_EN
   input  col_t               cursor_col,
   input  row_t               cursor_row,
`endif
   output logic [COLOR_W-1:0] pixel_out,
   output logic               de_out,
   output logic               hsync_out,
   output logic               vsync_out
);

   col_t               cell_col;
   logic [6:0]         cell_row;
   logic               in_range;
   logic [TADDR_W-1:0] cell_idx;
   logic               cursor_inv;
   logic [TADDR_W-1:0] tram_addr_reg;
   logic [6:0]         char_addr_reg;
   logic [2:0]         row_addr_reg;
   logic [COLOR_W-1:0] pixel_reg;
   logic [8:0]         side_a_q;
   logic [5:0]         side_b_q;
   logic [2:0]         sync_q;
   logic               font_bit;
   logic               unused_bits;

   assign cell_col = h_cnt[9:3];
   assign cell_row = v_cnt[9:3];
   assign in_range = (10'(cell_col) < 10'(H_CHARS)) && (10'(cell_row) < 10'(V_ROWS));
   assign cell_idx = TADDR_W'(32'(cell_row) * H_CHARS + 32'(cell_col));

`ifdef CHAR_CURSOR_EN
   logic [4:0] frame_cnt_reg;
   logic       vsync_prev_reg;

   // count vsync assertion edges; bit 4 gives a 32-frame blink
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_reg  <= '0;
         vsync_prev_reg <= SYNC_IDLE;
      end else begin
         vsync_prev_reg <= vsync_in;
         if (vsync_prev_reg == SYNC_IDLE && vsync_in != SYNC_IDLE)
            frame_cnt_reg <= frame_cnt_reg + 5'd1;
      end
   end

   assign cursor_inv = frame_cnt_reg[4] && (cell_col == cursor_col) &&
                       (cell_row == {1'b0, cursor_row});
`else
   assign cursor_inv = 1'b0;
`endif

   // E0: text RAM address; off-screen or blanked pixels read cell 0
   always_ff @(posedge clk) begin
      if (reset) tram_addr_reg <= '0;
      else       tram_addr_reg <= (de_in && in_range) ? cell_idx : '0;
   end

   // E0..E1: glyph row, pixel column, enable, in-range and cursor flag
   sig_delay_line #(.WIDTH(9), .DEPTH(2), .RESET_VAL('0)) u_side_a (
      .clk  (clk),
      .reset(reset),
      .din  ({v_cnt[2:0], h_cnt[2:0], de_in, in_range, cursor_inv}),
      .dout (side_a_q)
   );

   // E2: font ROM address from the fetched character and the carried row
   always_ff @(posedge clk) begin
      if (reset) begin
         char_addr_reg <= '0;
         row_addr_reg  <= '0;
      end else begin
         char_addr_reg <= mem.tram_data[6:0];
         row_addr_reg  <= side_a_q[8:6];
      end
   end

   // E2..E3: carry the per-pixel side band alongside the ROM access
   sig_delay_line #(.WIDTH(6), .DEPTH(2), .RESET_VAL('0)) u_side_b (
      .clk  (clk),
      .reset(reset),
      .din  (side_a_q[5:0]),
      .dout (side_b_q)
   );

   assign font_bit = mem.font_data[side_b_q[5:3]] ^ side_b_q[0];

   // E4: colour the pixel; blanking gives 0, off-screen cells give background
   always_ff @(posedge clk) begin
      if (reset)             pixel_reg <= '0;
      else if (!side_b_q[2]) pixel_reg <= '0;
      else if (side_b_q[1] && font_bit) pixel_reg <= fg_color;
      else                   pixel_reg <= bg_color;
   end

   // sync and enable follow the pixel pipe with identical latency
   sig_delay_line #(.WIDTH(3), .DEPTH(LAT), .RESET_VAL({SYNC_IDLE, SYNC_IDLE, 1'b0})) u_sync (
      .clk  (clk),
      .reset(reset),
      .din  ({hsync_in, vsync_in, de_in}),
      .dout (sync_q)
   );

   assign mem.tram_addr = tram_addr_reg;
   assign mem.char_addr = char_addr_reg;
   assign mem.row_addr  = row_addr_reg;
   assign pixel_out     = pixel_reg;
   assign hsync_out     = sync_q[2];
   assign vsync_out     = sync_q[1];
   assign de_out        = sync_q[0];
   assign unused_bits   = mem.tram_data[7];

endmodule

// File: tb/tb_char_text_renderer.sv
// Self-checking bench for char_text_renderer with text RAM and font ROM models.
// Define CHAR_CURSOR_EN to also exercise the block cursor.
module tb_char_text_renderer;
   import char_disp_pkg::*;

   typedef struct packed {
      logic [15:0] pix;
      logic        de;
      logic        hs;
      logic        vs;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  h_cnt, v_cnt;
   logic        de_in, hsync_in, vsync_in;
   logic [15:0] fg_color, bg_color, pixel_out;
   logic        de_out, hsync_out, vsync_out;
`ifdef CHAR_CURSOR_EN
   col_t        cursor_col;
   row_t        cursor_row;
`endif

   char_text_renderer_if #(.TADDR_W(13)) bus ();

   char_text_renderer dut (
      .clk       (clk),
      .reset     (reset),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .de_in     (de_in),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .mem       (bus),
      .fg_color  (fg_color),
      .bg_color  (bg_color),
`ifdef CHAR_CURSOR_EN
      .cursor_col(cursor_col),
      .cursor_row(cursor_row),
`endif
      .pixel_out (pixel_out),
      .de_out    (de_out),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out)
   );

   always #5 clk = ~clk;

   logic [7:0] tram [8192];
   logic [7:0] font [1024];

   // memories with one clock of read latency
   always @(posedge clk) begin
      bus.tram_data <= tram[bus.tram_addr];
      bus.font_data <= font[{bus.char_addr, bus.row_addr}];
   end

   obs_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   model_frames = 0;
   logic model_vs_prev = 1'b1;
   obs_t idle_obs = '{pix: 16'h0, de: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic obs_t got();
      return {pixel_out, de_out, hsync_out, vsync_out};
   endfunction

   // expected output for one input pixel, straight from the screen rules
   function automatic obs_t model(input int h, input int v, input logic de, hs, vs, inv);
      obs_t o;
      int col, row;
      logic [7:0] bits;
      o.de = de; o.hs = hs; o.vs = vs; o.pix = 16'h0;
      if (de) begin
         col = h / 8;
         row = v / 8;
         if (col >= 80 || row >= 60) o.pix = bg_color;
         else begin
            bits  = font[tram[row * 80 + col][6:0] * 8 + v % 8];
            o.pix = (bits[h % 8] ^ inv) ? fg_color : bg_color;
         end
      end
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // apply one pixel, advance a clock, and hand back the expectation now due
   task automatic cycle(input int h, input int v, input logic de, hs, vs,
                        output logic have, output obs_t e);
      logic inv;
      inv = 1'b0;
`ifdef CHAR_CURSOR_EN
      inv = (model_frames % 32 >= 16) && (h / 8 == int'(cursor_col)) && (v / 8 == int'(cursor_row));
`endif
      h_cnt = h[9:0]; v_cnt = v[9:0]; de_in = de; hsync_in = hs; vsync_in = vs;
      exp_q.push_back(model(h, v, de, hs, vs, inv));
      if (model_vs_prev && !vs) model_frames++;
      model_vs_prev = vs;
      step();
      have = 1'b0;
      e = idle_obs;
      if (exp_q.size() == LAT) begin
         e = exp_q.pop_front();
         have = 1'b1;
      end
   endtask

   task automatic hold_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   // after release the pipe delivers reset values for LAT-1 more pops
   task automatic release_reset();
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back(idle_obs);
      model_frames = 0;
      model_vs_prev = 1'b1;
   endtask

   task automatic test_reset();
      logic have; obs_t e;
      for (int i = 0; i < 10; i++) begin
         cycle(i * 3, 8, 1'b1, 1'b1, 1'b1, have, e);
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL pre_reset_stream: got %h expected %h", got(), e); end
         end
      end
      h_cnt = 10'd100; v_cnt = 10'd30; de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (got() !== idle_obs) begin bad++; $display("FAIL reset_outputs: got %h expected %h", got(), idle_obs); end
         total++;
         if ({bus.tram_addr, bus.char_addr, bus.row_addr} !== 23'h0) begin
            bad++; $display("FAIL reset_addrs: got %h expected 0", {bus.tram_addr, bus.char_addr, bus.row_addr});
         end
      end
      release_reset();
      for (int i = 0; i < 14; i++) begin
         cycle(8 + i, 9, 1'b1, 1'b1, 1'b1, have, e);
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL post_reset_stream %0d: got %h expected %h", i, got(), e); end
         end
      end
   endtask

   task automatic test_char_row();
      logic have; obs_t e;
      logic [7:0] pat;
      int pops;
      pat = 8'h1C;
      pops = 0;
      for (int i = 0; i < 8 + LAT; i++) begin
         if (i < 8) cycle(i, 0, 1'b1, 1'b1, 1'b1, have, e);
         else       cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
         if (i < 8) begin
            total++;
            if (bus.tram_addr !== 13'd0) begin bad++; $display("FAIL char_a_addr: got %0d expected 0", bus.tram_addr); end
         end
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL char_a_model %0d: got %h expected %h", i, got(), e); end
            if (pops >= LAT - 1 && pops < LAT + 7) begin
               total++;
               if (pixel_out !== (pat[pops - (LAT - 1)] ? fg_color : bg_color)) begin
                  bad++; $display("FAIL char_a_pixel h=%0d: got %h expected %h", pops - (LAT - 1), pixel_out,
                                  pat[pops - (LAT - 1)] ? fg_color : bg_color);
               end
            end
            pops++;
         end
      end
   endtask

   task automatic test_addr();
      logic have; obs_t e;
      cycle(40, 19, 1'b1, 1'b1, 1'b1, have, e);
      total++;
      if (bus.tram_addr !== 13'd165) begin bad++; $display("FAIL addr_165: got %0d expected 165", bus.tram_addr); end
      cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
      cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
      total++;
      if (bus.row_addr !== 3'd3) begin bad++; $display("FAIL row_addr: got %0d expected 3", bus.row_addr); end
      total++;
      if (bus.char_addr !== tram[165][6:0]) begin
         bad++; $display("FAIL char_addr: got %h expected %h", bus.char_addr, tram[165][6:0]);
      end
      for (int i = 0; i < LAT; i++) begin
         cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL addr_flush: got %h expected %h", got(), e); end
         end
      end
   endtask

   task automatic test_sync_random();
      logic have; obs_t e;
      for (int i = 0; i < 200; i++) begin
         cycle($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom), have, e);
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL sync_random %0d: got %h expected %h", i, got(), e); end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic have; obs_t e;
      cycle(648, 8, 1'b1, 1'b1, 1'b1, have, e);
      total++;
      if (bus.tram_addr !== 13'd0) begin bad++; $display("FAIL oor_col_addr: got %0d expected 0", bus.tram_addr); end
      for (int i = 0; i < LAT - 1; i++) cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
      total++;
      if (pixel_out !== bg_color || de_out !== 1'b1) begin
         bad++; $display("FAIL oor_col_pixel: got %h/%b expected %h/1", pixel_out, de_out, bg_color);
      end
      cycle(16, 480, 1'b1, 1'b1, 1'b1, have, e);
      total++;
      if (bus.tram_addr !== 13'd0) begin bad++; $display("FAIL oor_row_addr: got %0d expected 0", bus.tram_addr); end
      for (int i = 0; i < LAT - 1; i++) cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
      total++;
      if (pixel_out !== bg_color) begin bad++; $display("FAIL oor_row_pixel: got %h expected %h", pixel_out, bg_color); end
   endtask

   task automatic test_back_to_back();
      logic have; obs_t e;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 700), $urandom_range(0, 520), ($urandom_range(0, 7) != 0), 1'b1, 1'b1, have, e);
         if (have) begin
            total++;
            if (got() !== e) begin bad++; $display("FAIL back_to_back %0d: got %h expected %h", i, got(), e); end
         end
      end
   endtask

`ifdef CHAR_CURSOR_EN
   task automatic test_cursor();
      logic have; obs_t e;
      hold_reset(2);
      release_reset();
      tram[165] = 8'h20;
      for (int r = 0; r < 8; r++) font[8'h20 * 8 + r] = 8'h00;
      for (int f = 0; f < 34; f++) begin
         cycle(0, 0, 1'b0, 1'b1, 1'b0, have, e);
         if (have) begin total++; if (got() !== e) begin bad++; $display("FAIL cursor_vs: got %h expected %h", got(), e); end end
         cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
         if (have) begin total++; if (got() !== e) begin bad++; $display("FAIL cursor_vs: got %h expected %h", got(), e); end end
         cycle(40, 16, 1'b1, 1'b1, 1'b1, have, e);
         if (have) begin total++; if (got() !== e) begin bad++; $display("FAIL cursor_gap: got %h expected %h", got(), e); end end
         cycle(48, 16, 1'b1, 1'b1, 1'b1, have, e);
         if (have) begin total++; if (got() !== e) begin bad++; $display("FAIL cursor_gap: got %h expected %h", got(), e); end end
         for (int i = 0; i < LAT - 1; i++) begin
            cycle(0, 0, 1'b0, 1'b1, 1'b1, have, e);
            if (have) begin
               total++;
               if (got() !== e) begin bad++; $display("FAIL cursor_cell f=%0d: got %h expected %h", f, got(), e); end
            end
         end
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8192; i++) tram[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
      tram[0] = 8'h41;
      font[8'h41 * 8] = 8'h1C;
      fg_color = 16'($urandom_range(1, 16'hFFFF));
      bg_color = 16'($urandom_range(1, 16'hFFFF));
      if (bg_color == fg_color) bg_color = ~fg_color;
`ifdef CHAR_CURSOR_EN
      cursor_col = 7'd5;
      cursor_row = 6'd2;
`endif
      h_cnt = '0; v_cnt = '0; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      hold_reset(3);
      release_reset();
      test_reset();
      test_char_row();
      test_addr();
      test_sync_random();
      test_out_of_range();
      test_back_to_back();
`ifdef CHAR_CURSOR_EN
      test_cursor();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
